// File: rtl/dgt_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL bit layout and the active-low hex glyph table.
package dgt_scan_ctrl_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_DATA   = 32'h4;
    localparam logic [31:0] OFF_MASK   = 32'h8;
    localparam logic [31:0] OFF_STATUS = 32'hC;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_SIGNED = 1;
    localparam int unsigned CTRL_LZB    = 2;
    localparam int unsigned STATUS_TOG  = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hFE;

    // Field order mirrors the CTRL bit positions above (en is bit 0).
    typedef struct packed {
        logic lzb;
        logic sgn;
        logic en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{lzb: 1'b0, sgn: 1'b1, en: 1'b1};

    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
        8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8
    };

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        return HEX_GLYPH[n];
    endfunction

endpackage

// File: rtl/dgt_scan_ctrl_if.sv
// CPU data-bus port of the scan controller: byte address, write data/strobe
// and combinational read data.
interface dgt_scan_ctrl_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        We;
    logic [31:0] dataout;

    modport master (
        output addr,
        output datain,
        output We,
        input  dataout
    );

    modport slave (
        input  addr,
        input  datain,
        input  We,
        output dataout
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment glyph (bit7 = dp), purely combinational.
module seg7_hex_decode
    import dgt_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] glyph
);
    always_comb begin
        glyph = hex_glyph(nibble);
    end
endmodule

// File: rtl/dgt_scan_ctrl.sv
// Memory-mapped multiplexed seven-segment controller. The display is driven
// only from shadow copies of CTRL/DATA/MASK that refresh on each frame wrap.
module dgt_scan_ctrl
    import dgt_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SCAN_PRESET = 100000,
    parameter logic [31:0] BASE_ADDR   = 32'h00007f30
) (
    input  logic                  clk,
    input  logic                  reset,
    dgt_scan_ctrl_if.slave        bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            sign_seg
);

    localparam int unsigned      CNT_W    = (SCAN_PRESET > 1) ? $clog2(SCAN_PRESET) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCAN_PRESET - 1);
    localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);

    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + OFF_CTRL;
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + OFF_DATA;
    localparam logic [31:0] ADDR_MASK   = BASE_ADDR + OFF_MASK;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + OFF_STATUS;

    // Software-visible registers
    ctrl_t                 ctrl_q;
    logic [31:0]           data_q;
    logic [NUM_DIGITS-1:0] mask_q;

    // Frame-synchronous shadows
    ctrl_t                 sh_ctrl;
    logic [31:0]           sh_data;
    logic [NUM_DIGITS-1:0] sh_mask;

    // Scan state
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dig;
    logic             frame_tog;
    logic             tick;
    logic             wrap;

    // Write decode
    logic wr_ctrl;
    logic wr_data;
    logic wr_mask;

    // Value formation
    logic        neg;
    logic [31:0] mag;
    logic [3:0]  nibble;
    logic [7:0]  glyph;
    logic        upper_nz;
    logic        lz_blank;

    always_comb begin
        wr_ctrl = bus.We && (bus.addr == ADDR_CTRL);
        wr_data = bus.We && (bus.addr == ADDR_DATA);
        wr_mask = bus.We && (bus.addr == ADDR_MASK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= CTRL_RESET;
            data_q <= '0;
            mask_q <= '1;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= ctrl_t'(bus.datain[CTRL_LZB:CTRL_EN]);
            end
            if (wr_data) begin
                data_q <= bus.datain;
            end
            if (wr_mask) begin
                mask_q <= bus.datain[NUM_DIGITS-1:0];
            end
        end
    end

    always_comb begin
        tick = (cnt == '0);
        wrap = tick && (dig == DIG_LAST);
    end

    // Counter keeps running regardless of EN so frame timing never slips.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= CNT_LOAD;
            dig       <= '0;
            frame_tog <= 1'b0;
        end else if (tick) begin
            cnt <= CNT_LOAD;
            if (wrap) begin
                dig       <= '0;
                frame_tog <= ~frame_tog;
            end else begin
                dig <= dig + 3'd1;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A write on the wrap edge lands in the register; the shadow takes the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ctrl <= CTRL_RESET;
            sh_data <= '0;
            sh_mask <= '1;
        end else if (wrap) begin
            sh_ctrl <= ctrl_q;
            sh_data <= data_q;
            sh_mask <= mask_q;
        end
    end

    always_comb begin
        bus.dataout = '0;
        unique case (bus.addr)
            ADDR_CTRL:   bus.dataout[CTRL_LZB:CTRL_EN] = ctrl_q;
            ADDR_DATA:   bus.dataout = data_q;
            ADDR_MASK:   bus.dataout[NUM_DIGITS-1:0] = mask_q;
            ADDR_STATUS: begin
                bus.dataout[2:0]        = dig;
                bus.dataout[STATUS_TOG] = frame_tog;
            end
            default:     bus.dataout = '0;
        endcase
    end

    always_comb begin
        neg    = sh_ctrl.sgn && sh_data[31];
        mag    = neg ? (~sh_data + 32'd1) : sh_data;
        nibble = mag[{dig, 2'b00} +: 4];
    end

    // Digit d is leading-zero blank when it and every digit above it is zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= 32'(dig)) && (mag[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = sh_ctrl.lzb && (dig != 3'd0) && !upper_nz;
    end

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        sel      = '0;
        seg      = SEG_BLANK;
        sign_seg = SEG_BLANK;
        if (sh_ctrl.en) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                sel[i] = (32'(dig) == i);
            end
            sign_seg = neg ? SEG_MINUS : SEG_BLANK;
            if (sh_mask[dig] && !lz_blank) begin
                seg = glyph;
            end
        end
    end

endmodule

// File: tb/tb_dgt_scan_ctrl.sv
// Bench for dgt_scan_ctrl: directed scenarios with fixed expectations plus
// randomized bus traffic checked against a frame-time reference model.
module tb_dgt_scan_ctrl;

    localparam int N  = 8;
    localparam int P  = 4;
    localparam int NP = N * P;
    localparam logic [31:0] BASE   = 32'h00007f30;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_DATA = BASE + 32'd4;
    localparam logic [31:0] A_MASK = BASE + 32'd8;
    localparam logic [31:0] A_STAT = BASE + 32'd12;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   seg;
    logic [7:0]   sign_seg;
    logic [N-1:0] sel;

    dgt_scan_ctrl_if bus ();

    dgt_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SCAN_PRESET (P),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .seg      (seg),
        .sel      (sel),
        .sign_seg (sign_seg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] glyph_tab [16] = '{
        8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
        8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8
    };

    // Reference model: phase = cycles elapsed within the current frame.
    logic [31:0] m_ctrl = 32'd3, m_data = 32'd0, m_mask = 32'hFF;
    logic [31:0] s_ctrl = 32'd3, s_data = 32'd0, s_mask = 32'hFF;
    int          m_phase = 0;
    logic        m_tog = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ctrl  <= 32'd3;  m_data <= 32'd0;  m_mask <= 32'hFF;
            s_ctrl  <= 32'd3;  s_data <= 32'd0;  s_mask <= 32'hFF;
            m_phase <= 0;
            m_tog   <= 1'b0;
        end else begin
            if (m_phase == NP - 1) begin
                s_ctrl <= m_ctrl;
                s_data <= m_data;
                s_mask <= m_mask;
                m_tog  <= ~m_tog;
            end
            m_phase <= (m_phase + 1) % NP;
            if (bus.We) begin
                if (bus.addr == A_CTRL) m_ctrl <= bus.datain & 32'h7;
                if (bus.addr == A_DATA) m_data <= bus.datain;
                if (bus.addr == A_MASK) m_mask <= bus.datain & 32'hFF;
            end
        end
    end

    function automatic logic [23:0] exp_disp();
        int d;
        logic neg;
        logic [31:0] mag, upper;
        logic [7:0] sg;
        d = m_phase / P;
        if (!s_ctrl[0]) return {8'h00, 8'hFF, 8'hFF};
        neg   = s_ctrl[1] && s_data[31];
        mag   = neg ? (32'd0 - s_data) : s_data;
        upper = mag >> (4 * d);
        if (!s_mask[d])                      sg = 8'hFF;
        else if (s_ctrl[2] && d > 0 && upper == 0) sg = 8'hFF;
        else                                 sg = glyph_tab[upper[3:0]];
        return {8'(1 << d), sg, neg ? 8'hFE : 8'hFF};
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == A_CTRL) return m_ctrl;
        if (a == A_DATA) return m_data;
        if (a == A_MASK) return m_mask;
        if (a == A_STAT) return {23'd0, m_tog, 5'd0, 3'(m_phase / P)};
        return 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.datain = d;
        bus.We     = 1'b1;
        step();
        bus.We     = 1'b0;
    endtask

    task automatic wait_wrap();
        step();
        for (int i = 0; i < NP + 2 && m_phase != 0; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({sel, seg, sign_seg} !== 24'h0181FF) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0181ff", {sel, seg, sign_seg});
        end
        bus.addr = A_CTRL; #1;
        n_cmp++;
        if (bus.dataout !== 32'h3) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h want 00000003", bus.dataout);
        end
        bus.addr = A_MASK; #1;
        n_cmp++;
        if (bus.dataout !== 32'hFF) begin
            n_err++;
            $display("FAIL reset_mask: got %h want 000000ff", bus.dataout);
        end
        bus.addr = A_STAT; #1;
        n_cmp++;
        if (bus.dataout !== 32'h0) begin
            n_err++;
            $display("FAIL reset_status: got %h want 00000000", bus.dataout);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_walk();
        bus.addr = A_STAT;
        for (int k = 1; k <= NP; k++) begin
            logic [23:0] want;
            logic [31:0] st;
            step();
            want = {8'(1 << ((k % NP) / P)), 8'h81, 8'hFF};
            st   = {23'd0, (k >= NP), 5'd0, 3'((k % NP) / P)};
            n_cmp++;
            if ({sel, seg, sign_seg} !== want) begin
                n_err++;
                $display("FAIL scan_walk k=%0d: got %h want %h", k, {sel, seg, sign_seg}, want);
            end
            n_cmp++;
            if (bus.dataout !== st) begin
                n_err++;
                $display("FAIL scan_status k=%0d: got %h want %h", k, bus.dataout, st);
            end
        end
    endtask

    task automatic test_data_midframe();
        logic [7:0] tab [8] = '{8'hC2, 8'hB1, 8'hE0, 8'h88, 8'hCC, 8'h86, 8'h92, 8'hCF};
        for (int i = 0; i < 10; i++) step();
        bus_write(A_DATA, 32'h1234ABCD);
        for (int i = 0; i < NP && m_phase != 0; i++) begin
            n_cmp++;
            if (seg !== 8'h81) begin
                n_err++;
                $display("FAIL midframe_hold: got %h want 81", seg);
            end
            step();
        end
        for (int c = 0; c < NP; c++) begin
            n_cmp++;
            if ({sel, seg, sign_seg} !== {8'(1 << (c / P)), tab[c / P], 8'hFF}) begin
                n_err++;
                $display("FAIL data_digits c=%0d: got %h want %h", c, {sel, seg, sign_seg},
                         {8'(1 << (c / P)), tab[c / P], 8'hFF});
            end
            step();
        end
    endtask

    task automatic test_signed();
        bus_write(A_CTRL, 32'h3);
        bus_write(A_DATA, 32'hFFFFFFFF);
        wait_wrap();
        for (int c = 0; c < NP; c++) begin
            logic [7:0] w;
            w = (c / P == 0) ? 8'hCF : 8'h81;
            n_cmp++;
            if ({seg, sign_seg} !== {w, 8'hFE}) begin
                n_err++;
                $display("FAIL signed_minus1 c=%0d: got %h want %h", c, {seg, sign_seg}, {w, 8'hFE});
            end
            step();
        end
        bus_write(A_CTRL, 32'h7);
        wait_wrap();
        for (int c = 0; c < NP; c++) begin
            logic [7:0] w;
            w = (c / P == 0) ? 8'hCF : 8'hFF;
            n_cmp++;
            if ({seg, sign_seg} !== {w, 8'hFE}) begin
                n_err++;
                $display("FAIL signed_lzb c=%0d: got %h want %h", c, {seg, sign_seg}, {w, 8'hFE});
            end
            step();
        end
    endtask

    task automatic test_min_neg();
        bus_write(A_CTRL, 32'h3);
        bus_write(A_DATA, 32'h80000000);
        wait_wrap();
        for (int c = 0; c < NP; c++) begin
            logic [7:0] w;
            w = (c / P == 7) ? 8'h80 : 8'h81;
            n_cmp++;
            if ({seg, sign_seg} !== {w, 8'hFE}) begin
                n_err++;
                $display("FAIL minneg_signed c=%0d: got %h want %h", c, {seg, sign_seg}, {w, 8'hFE});
            end
            step();
        end
        bus_write(A_CTRL, 32'h1);
        wait_wrap();
        for (int c = 0; c < NP; c++) begin
            logic [7:0] w;
            w = (c / P == 7) ? 8'h80 : 8'h81;
            n_cmp++;
            if ({seg, sign_seg} !== {w, 8'hFF}) begin
                n_err++;
                $display("FAIL minneg_raw c=%0d: got %h want %h", c, {seg, sign_seg}, {w, 8'hFF});
            end
            step();
        end
    endtask

    task automatic test_mask_enable();
        bus_write(A_MASK, 32'h0F);
        wait_wrap();
        for (int c = 0; c < NP; c++) begin
            logic [7:0] w;
            w = (c / P >= 4) ? 8'hFF : 8'h81;
            n_cmp++;
            if ({sel, seg} !== {8'(1 << (c / P)), w}) begin
                n_err++;
                $display("FAIL mask c=%0d: got %h want %h", c, {sel, seg}, {8'(1 << (c / P)), w});
            end
            step();
        end
        bus_write(A_CTRL, 32'h0);
        wait_wrap();
        bus.addr = A_STAT;
        for (int c = 0; c < NP; c++) begin
            #1;
            n_cmp++;
            if ({sel, seg, sign_seg} !== 24'h00FFFF) begin
                n_err++;
                $display("FAIL disabled c=%0d: got %h want 00ffff", c, {sel, seg, sign_seg});
            end
            n_cmp++;
            if (bus.dataout[2:0] !== 3'(c / P)) begin
                n_err++;
                $display("FAIL disabled_status c=%0d: got %0d want %0d", c, bus.dataout[2:0], c / P);
            end
            step();
        end
    endtask

    task automatic test_wrap_write_and_reset();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_MASK, 32'hFF);
        bus_write(A_DATA, 32'h7);
        wait_wrap();
        for (int i = 0; i < NP + 2 && m_phase != NP - 1; i++) step();
        bus_write(A_DATA, 32'h5);
        bus.addr = A_DATA;
        for (int c = 0; c < 2 * NP; c++) begin
            logic [7:0] w;
            #1;
            w = (c / P != 0 && c / P != N) ? 8'h81 : ((c < NP) ? 8'h8F : 8'hA4);
            n_cmp++;
            if (seg !== w) begin
                n_err++;
                $display("FAIL wrap_write c=%0d: got %h want %h", c, seg, w);
            end
            n_cmp++;
            if (bus.dataout !== 32'h5) begin
                n_err++;
                $display("FAIL wrap_readback c=%0d: got %h want 00000005", c, bus.dataout);
            end
            step();
        end
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({sel, seg, sign_seg} !== 24'h0181FF) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h want 0181ff", {sel, seg, sign_seg});
        end
        #1;
        n_cmp++;
        if (bus.dataout !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_data: got %h want 00000000", bus.dataout);
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs [6] = '{A_CTRL, A_DATA, A_MASK, A_STAT, BASE + 32'd16, BASE + 32'd2};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            a = addrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) < 3) begin
                d = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) d = ~d;
                if (a == A_CTRL && $urandom_range(0, 3) != 0) d = d | 32'h1;
                bus_write(a, d);
            end else begin
                bus.addr = a;
                #1;
                n_cmp++;
                if (bus.dataout !== exp_read(a)) begin
                    n_err++;
                    $display("FAIL rand_read addr=%h: got %h want %h", a, bus.dataout, exp_read(a));
                end
                step();
            end
            n_cmp++;
            if ({sel, seg, sign_seg} !== exp_disp()) begin
                n_err++;
                $display("FAIL rand_disp n=%0d: got %h want %h", n, {sel, seg, sign_seg}, exp_disp());
            end
        end
    endtask

    initial begin
        bus.addr   = '0;
        bus.datain = '0;
        bus.We     = 1'b0;
        test_reset();
        test_scan_walk();
        test_data_midframe();
        test_signed();
        test_min_neg();
        test_mask_enable();
        test_wrap_write_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
